uart_calc_engine: RTL and testbench

Parametrised ASCII command calculator between the UART receiver's byte output and the UART transmitter's byte input. It parses lines of the form `<A>-<B>-<op>\n`, where A and B are unsigned decimal operands of up to DIGITS digits. It executes add/sub/mul/div on W-bit operands with a sequential divider, then streams a decimal result line back through a valid/ready byte handshake. Malformed input, overflow and divide-by-zero return an error line instead of a silent wrong result.

---
 rtl/uart_calc_engine.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_calc_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_calc_engine.sv
// ASCII "<A>-<B>-<op>\n" calculator placed between a UART receiver and transmitter.
// Parses the line, executes (with a restoring divider), converts by double-dabble and streams the result.
module uart_calc_engine #(
    parameter int unsigned DIGITS = 5,
    parameter int unsigned W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       overrun
);
    localparam int unsigned AW = W + 4;
    localparam int unsigned RW = 2 * W;
    localparam int unsigned ND = (RW * 30103) / 100000 + 1;
    localparam int unsigned CW = $clog2(RW + 16);
    localparam logic [7:0]  LF = 8'h0A;

    typedef enum logic [2:0] {
        PARSE_A, PARSE_B, PARSE_OP, DISCARD, EXEC, DIVIDE, CONVERT, SEND
    } state_t;

    typedef enum logic [2:0] {
        TX_ERR, TX_EQ, TX_SIGN, TX_DIGIT, TX_NL
    } tx_t;

    state_t          state;
    tx_t             tx_step;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [23:0]     op_buf;
    logic            err;
    logic            neg;
    logic [RW-1:0]   r;
    logic [W-1:0]    rem;
    logic [4*ND-1:0] bcd;

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    logic          is_digit;
    logic [AW-1:0] acc_next;
    logic          acc_bad;
    always_comb begin
        is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
        acc_next = acc * AW'(10) + AW'(in_data[3:0]);
        acc_bad  = (acc_next > AW'({W{1'b1}})) || (cnt >= CW'(DIGITS));
    end

    logic op_add, op_sub, op_mul, op_div, exec_err;
    always_comb begin
        op_add   = (op_buf == "add");
        op_sub   = (op_buf == "sub");
        op_mul   = (op_buf == "mul");
        op_div   = (op_buf == "div");
        exec_err = err || !(op_add || op_sub || op_mul || op_div) || (op_div && (b == '0));
    end

    // Restoring division: quotient bits shift into r[W-1:0] as the dividend shifts out.
    logic [W:0] div_shift;
    logic [W:0] div_diff;
    always_comb begin
        div_shift = {rem, r[W-1]};
        div_diff  = div_shift - {1'b0, b};
    end

    logic [4*ND-1:0] bcd_adj;
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
    end

    // Highest non-zero BCD digit drives leading-zero suppression; a zero result still sends digit 0.
    logic [CW-1:0] first_dig;
    logic [CW-1:0] prev_idx;
    logic [3:0]    dig_first;
    logic [3:0]    dig_prev;
    logic          r_nonzero;
    always_comb begin
        first_dig = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] != 4'd0) first_dig = CW'(i);
        end
        prev_idx  = cnt - CW'(1);
        dig_first = bcd[{first_dig, 2'b00} +: 4];
        dig_prev  = bcd[{prev_idx, 2'b00} +: 4];
        r_nonzero = |bcd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PARSE_A;
            tx_step   <= TX_EQ;
            acc       <= '0;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            op_buf    <= '0;
            err       <= 1'b0;
            neg       <= 1'b0;
            r         <= '0;
            rem       <= '0;
            bcd       <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (in_valid && !in_ready) overrun <= 1'b1;
            case (state)
                PARSE_A, PARSE_B: begin
                    if (in_valid) begin
                        if (is_digit) begin
                            if (acc_bad) begin
                                err   <= 1'b1;
                                state <= DISCARD;
                            end else begin
                                acc <= acc_next;
                                cnt <= cnt + CW'(1);
                            end
                        end else if (in_data == "-") begin
                            if (cnt == '0) begin
                                err   <= 1'b1;
                                state <= DISCARD;
                            end else begin
                                if (state == PARSE_A) begin
                                    a     <= acc[W-1:0];
                                    state <= PARSE_B;
                                end else begin
                                    b     <= acc[W-1:0];
                                    state <= PARSE_OP;
                                end
                                acc <= '0;
                                cnt <= '0;
                            end
                        end else if (in_data == LF) begin
                            err      <= 1'b1;
                            state    <= EXEC;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                end
                PARSE_OP: begin
                    if (in_valid) begin
                        if (in_data == LF) begin
                            if (cnt != CW'(3)) err <= 1'b1;
                            state    <= EXEC;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else if (cnt == CW'(3)) begin
                            err   <= 1'b1;
                            state <= DISCARD;
                        end else begin
                            op_buf <= {op_buf[15:0], in_data};
                            cnt    <= cnt + CW'(1);
                        end
                    end
                end
                DISCARD: begin
                    if (in_valid && (in_data == LF)) begin
                        state    <= EXEC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                EXEC: begin
                    cnt <= '0;
                    bcd <= '0;
                    if (exec_err) begin
                        state     <= SEND;
                        tx_step   <= TX_ERR;
                        out_valid <= 1'b1;
                        out_data  <= "E";
                    end else if (op_div) begin
                        r     <= RW'(a);
                        rem   <= '0;
                        state <= DIVIDE;
                    end else begin
                        if (op_add) r <= RW'(a) + RW'(b);
                        else if (op_mul) r <= RW'(a) * RW'(b);
                        else begin
                            r   <= (a >= b) ? RW'(a - b) : RW'(b - a);
                            neg <= (a < b);
                        end
                        state <= CONVERT;
                    end
                end
                DIVIDE: begin
                    if (!div_diff[W]) rem <= div_diff[W-1:0];
                    else rem <= div_shift[W-1:0];
                    r[W-1:0] <= {r[W-2:0], ~div_diff[W]};
                    if (cnt == CW'(W - 1)) begin
                        cnt   <= '0;
                        state <= CONVERT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CONVERT: begin
                    {bcd, r} <= {bcd_adj, r} << 1;
                    if (cnt == CW'(RW - 1)) begin
                        cnt       <= '0;
                        state     <= SEND;
                        tx_step   <= TX_EQ;
                        out_valid <= 1'b1;
                        out_data  <= "=";
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        case (tx_step)
                            TX_ERR: begin
                                if (cnt == CW'(2)) begin
                                    out_data <= LF;
                                    tx_step  <= TX_NL;
                                end else begin
                                    out_data <= "R";
                                    cnt      <= cnt + CW'(1);
                                end
                            end
                            TX_EQ, TX_SIGN: begin
                                if ((tx_step == TX_EQ) && neg && r_nonzero) begin
                                    out_data <= "-";
                                    tx_step  <= TX_SIGN;
                                end else begin
                                    out_data <= ascii_digit(dig_first);
                                    cnt      <= first_dig;
                                    tx_step  <= TX_DIGIT;
                                end
                            end
                            TX_DIGIT: begin
                                if (cnt == '0) begin
                                    out_data <= LF;
                                    tx_step  <= TX_NL;
                                end else begin
                                    out_data <= ascii_digit(dig_prev);
                                    cnt      <= prev_idx;
                                end
                            end
                            default: begin
                                out_valid <= 1'b0;
                                state     <= PARSE_A;
                                tx_step   <= TX_EQ;
                                in_ready  <= 1'b1;
                                busy      <= 1'b0;
                                acc       <= '0;
                                cnt       <= '0;
                                a         <= '0;
                                b         <= '0;
                                op_buf    <= '0;
                                err       <= 1'b0;
                                neg       <= 1'b0;
                                r         <= '0;
                                bcd       <= '0;
                            end
                        endcase
                    end
                end
                default: state <= PARSE_A;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_calc_engine.sv
// Bench for uart_calc_engine: vector table of command lines with a byte scoreboard and latency checks.
module tb_uart_calc_engine;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       overrun;

    always #5 clk = ~clk;

    uart_calc_engine #(.DIGITS(5), .W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .overrun(overrun)
    );

    typedef struct {
        string       line;
        string       resp;
        int unsigned lat;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        await_first = 1'b0;
    int unsigned exp_first = 0;
    int unsigned t_nl = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        random_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted output byte is matched against the queue in order.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid || out_data != prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%0b out_data=%h, required out_valid=1 out_data=%h",
                             out_valid, out_data, prev_data);
                end
            end
            if (await_first && out_valid) begin
                checks++;
                if (cyc != exp_first) begin
                    errors++;
                    $display("FAIL first_valid_latency: cycle %0d, required cycle %0d (T=%0d)", cyc, exp_first, t_nl);
                end
                await_first = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %h, required no byte", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data != e) begin
                        errors++;
                        $display("FAIL out_byte: got %h, required %h", out_data, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic void add_vec(input string l, input string r, input int unsigned lat);
        vec_t v;
        v.line = l;
        v.resp = r;
        v.lat  = lat;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic send_line(input string l, input string r, input int unsigned lat);
        for (int i = 0; i < r.len(); i++) exp_q.push_back(r[i]);
        for (int i = 0; i < l.len(); i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = l[i];
            if (i == l.len() - 1) begin
                t_nl        = cyc;
                exp_first   = cyc + lat;
                await_first = 1'b1;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("in_ready_after_nl", {31'd0, in_ready}, 32'd0);
        check("busy_after_nl", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned n = 0;
        while (!(exp_q.size() == 0 && !out_valid && in_ready && !await_first) && n < budget) begin
            @(posedge clk); #1;
            if (random_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL response_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
            await_first = 1'b0;
        end
    endtask

    task automatic pulse_reset_and_check(input string name);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = "5";
        @(posedge clk); #1;
        check({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({name, "_overrun"}, {31'd0, overrun}, 32'd0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        await_first = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        add_vec("123-45-add\n",       "=168\n",        34);
        add_vec("5-9-sub\n",          "=-4\n",         34);
        add_vec("9-9-sub\n",          "=0\n",          34);
        add_vec("65535-65535-mul\n",  "=4294836225\n", 34);
        add_vec("7-2-div\n",          "=3\n",          50);
        add_vec("100-0-div\n",        "ERR\n",         2);
        add_vec("65536-1-add\n",      "ERR\n",         2);
        add_vec("123456-1-add\n",     "ERR\n",         2);
        add_vec("12-3-xor\n",         "ERR\n",         2);
        add_vec("1x-2-add\n",         "ERR\n",         2);
        add_vec("0-0-add\n",          "=0\n",          34);
        add_vec("65535-65535-add\n",  "=131070\n",     34);
        add_vec("-1-add\n",           "ERR\n",         2);
        add_vec("1-2-ad\n",           "ERR\n",         2);
        add_vec("1-2-addd\n",         "ERR\n",         2);
        add_vec("1\n",                "ERR\n",         2);
        add_vec("00012-3-mul\n",      "=36\n",         34);
        add_vec("65535-1-div\n",      "=65535\n",      50);
        add_vec("4-1-sub\n",          "=3\n",          34);

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data", {24'd0, out_data}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            send_line(vecs[k].line, vecs[k].resp, vecs[k].lat);
            wait_done(300);
            check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        end

        // Random backpressure on the result stream.
        random_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send_line("123-45-add\n", "=168\n", 34);
            wait_done(400);
        end
        send_line("65535-65535-mul\n", "=4294836225\n", 34);
        wait_done(500);
        random_ready = 1'b0;

        // Bytes arriving while busy are dropped and flagged.
        check("overrun_before", {31'd0, overrun}, 32'd0);
        send_line("123-45-add\n", "=168\n", 34);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = "9";
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_done(300);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset in the middle of a division.
        send_line("7-2-div\n", "=3\n", 50);
        repeat (5) begin @(posedge clk); #1; end
        pulse_reset_and_check("reset_mid_divide");
        send_line("1-1-add\n", "=2\n", 34);
        wait_done(300);

        // Reset after part of the response has gone out.
        send_line("123-45-add\n", "=168\n", 34);
        begin
            int unsigned n = 0;
            while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
            check("send_reached", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk); #1;
        pulse_reset_and_check("reset_mid_send");
        send_line("1-1-add\n", "=2\n", 34);
        wait_done(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
